// File: rtl/genius_pkg.sv
// genius_pkg: shared Genius state codes (also decoded by the unit control hexa7seg debug) and default LED on/off cycle counts
package genius_pkg;
  localparam logic [3:0] ST_IDLE  = 4'd0;
  localparam logic [3:0] ST_FETCH = 4'd1;
  localparam logic [3:0] ST_LOAD  = 4'd2;
  localparam logic [3:0] ST_SHOW  = 4'd3;
  localparam logic [3:0] ST_GAP   = 4'd4;
  localparam logic [3:0] ST_DONE  = 4'd5;
  localparam int ON_CYCLES_DEF  = 1000;
  localparam int OFF_CYCLES_DEF = 500;
endpackage

// File: rtl/interval_timer.sv
// interval_timer: CNT_W up-counter; ports clock, reset (async low), clear, en, tc_value -> tc (count==tc_value)
module interval_timer #(
  parameter int CNT_W = 12
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  input  logic [CNT_W-1:0] tc_value,
  output logic             tc
);
  logic [CNT_W-1:0] count;
  always_ff @(posedge clock or negedge reset)
    if (!reset) count <= '0;
    else if (clear) count <= '0;
    else if (en) count <= count + 1'b1;
  assign tc = count == tc_value;
endmodule

// File: rtl/sequence_presenter.sv
// sequence_presenter: shows ROM entries 0..rodada on leds (ON lit, OFF blank); ports clock, reset (async low), start, rodada, mem_data, [abort if SEQ_PRESENTER_ABORT_EN] -> mem_addr, leds, busy, done, db_estado
module sequence_presenter
  import genius_pkg::*;
#(
  parameter int ADDR_W     = 4,
  parameter int DATA_W     = 4,
  parameter int CNT_W      = 12,
  parameter int ON_CYCLES  = ON_CYCLES_DEF,
  parameter int OFF_CYCLES = OFF_CYCLES_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
`ifdef SEQ_PRESENTER_ABORT_EN
  input  logic              abort,
`endif
  input  logic [ADDR_W-1:0] rodada,
  input  logic [DATA_W-1:0] mem_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] leds,
  output logic              busy,
  output logic              done,
  output logic [3:0]        db_estado
);
  logic [3:0]        state;
  logic [ADDR_W-1:0] last;
  logic              timing, tc, kill;
  assign timing = state == ST_SHOW || state == ST_GAP;
`ifdef SEQ_PRESENTER_ABORT_EN
  assign kill = abort && state != ST_IDLE;
`else
  assign kill = 1'b0;
`endif
  interval_timer #(.CNT_W(CNT_W)) u_timer (
    .clock    (clock),
    .reset    (reset),
    .clear    (!timing || tc),
    .en       (1'b1),
    .tc_value (state == ST_SHOW ? CNT_W'(ON_CYCLES - 1) : CNT_W'(OFF_CYCLES - 1)),
    .tc       (tc)
  );
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state    <= ST_IDLE;
      leds     <= '0;
      mem_addr <= '0;
      last     <= '0;
    end else if (kill) begin
      state <= ST_IDLE;
      leds  <= '0;
    end else
      case (state)
        ST_IDLE: if (start) begin
          last     <= rodada;
          mem_addr <= '0;
          state    <= ST_FETCH;
        end
        ST_FETCH: state <= ST_LOAD;
        ST_LOAD: begin
          leds  <= mem_data;
          state <= ST_SHOW;
        end
        ST_SHOW: if (tc) begin
          leds  <= '0;
          state <= ST_GAP;
        end
        ST_GAP: if (tc) begin
          state <= mem_addr == last ? ST_DONE : ST_FETCH;
          if (mem_addr != last) mem_addr <= mem_addr + 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
  assign done      = state == ST_DONE;
  assign busy      = timing || state == ST_FETCH || state == ST_LOAD;
  assign db_estado = state;
endmodule

// File: tb/tb_sequence_presenter.sv
// tb_sequence_presenter: directed vector bench for sequence_presenter with ON=3, OFF=2 and a 16-entry synchronous ROM model
module tb_sequence_presenter;
  logic       clk = 1'b0, reset = 1'b0, start = 1'b0, abort = 1'b0;
  logic [3:0] rodada = '0, mem_data = '0, mem_addr, leds, db_estado;
  logic       busy, done;
  logic [3:0] rom [16];
  int tests = 0, failed = 0;
  typedef struct {
    logic [3:0] rodada;
    bit         repulse;
    int         done_k;
  } vec_t;
  vec_t vecs [4];
  always #5 clk = ~clk;
  always_ff @(posedge clk) mem_data <= rom[mem_addr];
  sequence_presenter #(.ON_CYCLES(3), .OFF_CYCLES(2)) dut (
    .clock     (clk),
    .reset     (reset),
    .start     (start),
`ifdef SEQ_PRESENTER_ABORT_EN
    .abort     (abort),
`endif
    .rodada    (rodada),
    .mem_data  (mem_data),
    .mem_addr  (mem_addr),
    .leds      (leds),
    .busy      (busy),
    .done      (done),
    .db_estado (db_estado)
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic check_idle(input string tag, input logic [3:0] addr);
    check({tag, " leds"}, 32'(leds), 0);
    check({tag, " busy"}, 32'(busy), 0);
    check({tag, " done"}, 32'(done), 0);
    check({tag, " db"}, 32'(db_estado), 0);
    check({tag, " addr"}, 32'(mem_addr), 32'(addr));
  endtask
  // k counts clock edges after the start edge; each entry spans FETCH, LOAD, 3 SHOW, 2 GAP = 7 cycles
  task automatic check_cycle(input logic [3:0] last, input int kd, input int k);
    int n, o;
    logic [3:0] el, ea, ed;
    logic eb, edn;
    n = k / 7;
    o = k % 7;
    if (k < kd) begin
      el = (o >= 2 && o <= 4) ? rom[n] : 4'd0;
      ea = 4'(n);
      eb = 1'b1;
      edn = 1'b0;
      ed = o == 0 ? 4'd1 : o == 1 ? 4'd2 : o <= 4 ? 4'd3 : 4'd4;
    end else begin
      el = 4'd0;
      ea = last;
      eb = 1'b0;
      edn = k == kd;
      ed = k == kd ? 4'd5 : 4'd0;
    end
    check($sformatf("r%0d k%0d leds", last, k), 32'(leds), 32'(el));
    check($sformatf("r%0d k%0d addr", last, k), 32'(mem_addr), 32'(ea));
    check($sformatf("r%0d k%0d busy", last, k), 32'(busy), 32'(eb));
    check($sformatf("r%0d k%0d done", last, k), 32'(done), 32'(edn));
    check($sformatf("r%0d k%0d db", last, k), 32'(db_estado), 32'(ed));
  endtask
  task automatic run_case(input vec_t v);
    rodada = v.rodada;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k <= v.done_k + 2; k++) begin
      check_cycle(v.rodada, v.done_k, k);
      if (v.repulse) begin
        if (k == 10) begin start = 1'b1; rodada = 4'd1; end
        if (k == 12) start = 1'b0;
        if (k == v.done_k) start = 1'b1;
        if (k == v.done_k + 1) start = 1'b0;
      end
      if (k < v.done_k + 2) begin @(posedge clk); #1; end
    end
  endtask
  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 4'(i);
    rom[0] = 4'd1; rom[1] = 4'd2; rom[2] = 4'd4; rom[3] = 4'd8; rom[5] = 4'd0;
    vecs[0] = '{rodada: 4'd0,  repulse: 1'b0, done_k: 7};
    vecs[1] = '{rodada: 4'd3,  repulse: 1'b0, done_k: 28};
    vecs[2] = '{rodada: 4'd3,  repulse: 1'b1, done_k: 28};
    vecs[3] = '{rodada: 4'd15, repulse: 1'b0, done_k: 112};
    #2 check_idle("reset", 4'd0);
    #20 reset = 1'b1;
    @(posedge clk); #1;
    check_idle("idle", 4'd0);
    foreach (vecs[i]) run_case(vecs[i]);
    rodada = 4'd3;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin @(posedge clk); #1; end
    check("midshow db", 32'(db_estado), 3);
    check("midshow leds", 32'(leds), 1);
    #2 reset = 1'b0;
    #1 check_idle("async reset", 4'd0);
    #3 reset = 1'b1;
    begin
      logic seen = 1'b0;
      for (int k = 0; k < 40; k++) begin
        @(posedge clk); #1;
        seen |= done | busy;
      end
      check("no done after reset", 32'(seen), 0);
    end
`ifdef SEQ_PRESENTER_ABORT_EN
    rodada = 4'd3;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 9; k++) begin @(posedge clk); #1; end
    check("abort pre db", 32'(db_estado), 3);
    check("abort pre leds", 32'(leds), 2);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check_idle("abort", 4'd1);
    begin
      logic seen = 1'b0;
      for (int k = 0; k < 40; k++) begin
        @(posedge clk); #1;
        seen |= done | busy;
      end
      check("no done after abort", 32'(seen), 0);
    end
`endif
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
